// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock. A single
//   four_bit_rca does all the arithmetic, and the carry between nibbles is
//   held in a register. Both sides use a valid/ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | in_ready=1, waits for in_valid, then latches a/b/cin
//   ADD   | one nibble per cycle through the rca, LSB nibble first
//   DONE  | out_valid=1, result held until out_ready
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   rst       synchronous active-high reset
//   in_valid  a, b and cin are valid
//   in_ready  block can accept operands (IDLE)
//   a, b      W-bit operands
//   cin       carry into nibble 0
//   out_valid sum, cout and ovf are valid (DONE)
//   out_ready consumer accepts the result
//   sum       (a + b + cin) mod 2^W
//   cout      unsigned carry out of the MSB nibble
//   ovf       two's-complement overflow

module four_bit_rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             cin_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  logic [3:0] rca_a;
  logic [3:0] rca_b;
  logic       rca_cin;
  logic [3:0] rca_s;
  logic       rca_cout;

  assign rca_a   = a_reg[4*idx +: 4];
  assign rca_b   = b_reg[4*idx +: 4];
  // The first nibble takes the external carry and later nibbles take the
  // carry registered from the previous nibble.
  assign rca_cin = (idx == '0) ? cin_reg : carry_reg;

  four_bit_rca u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (rca_cin),
    .s    (rca_s),
    .cout (rca_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            cin_reg <= cin;
            sum     <= '0;
            idx     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum[4*idx +: 4] <= rca_s;
          carry_reg       <= rca_cout;
          idx             <= idx + 1'b1;
          if (idx == LAST) begin
            cout  <= rca_cout;
            // Overflow happens when both operands have the same sign and the
            // result sign differs. rca_s[3] is the result MSB on this cycle.
            ovf   <= (a_reg[W-1] == b_reg[W-1]) && (rca_s[3] != a_reg[W-1]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential multi-word adder that sums two NIBBLES*4-bit operands one nibble per clock through a single instantiated four_bit_rca.
- Sits upstream of and wraps the four_bit_rca: it drives the adder's A/B/Cin nibble by nibble and consumes S/Cout, registering the carry between nibbles.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  A+B+cin, modulo 2^W.
- cout  output  1  carry out of the MSB nibble.
- ovf  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: when rst=1 at a rising edge, the following take effect that edge:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - internal carry and nibble index = 0.
- Reset overrides every other input.
- Reset mid-operation, in ADD or DONE, aborts with no partial result presented.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a, b and cin into internal registers, clear sum to 0, set idx=0, go to ADD.
  - With in_valid=0: stay in IDLE.
- ADD:
  - in_ready=0, out_valid=0.
  - Combinationally drive the four_bit_rca with A=a_reg[4*idx+3:4*idx], B=b_reg nibble idx, Cin=carry_reg (cin_reg when idx=0).
  - At each edge:
    - sum[4*idx+3:4*idx] <= S.
    - carry_reg <= Cout.
    - idx <= idx+1.
  - When idx=NIBBLES-1, at that edge also:
    - cout <= Cout.
    - ovf <= (a_reg[W-1]==b_reg[W-1]) && (S[3]!=a_reg[W-1]).
    - go to DONE.
  - in_valid is ignored in ADD; no input is lost because in_ready=0.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable.
  - On an edge with out_ready=1: go to IDLE; sum, cout and ovf keep their values, and out_valid drops.
  - With out_ready=0: hold indefinitely, with outputs unchanged.
- Latency: out_valid rises exactly NIBBLES cycles after the input-accept edge (4 cycles at the default).
- Throughput: one result per NIBBLES+2 cycles minimum, with no overlap between the DONE and IDLE accept.
- Width rules:
  - sum wraps modulo 2^W.
  - cout is the true unsigned carry.
  - ovf is valid for two's-complement interpretation.
  - The first nibble's carry-in is cin.
- Operands are sampled only on the accept edge; changes to a, b or cin afterward have no effect.
- NIBBLES=1 degenerates to a single ADD cycle: IDLE -> ADD -> DONE.

Test Plan:
- Reset then idle: assert rst for 2 cycles → in_ready=1, out_valid=0, sum=0x0000, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, out_ready=1 → out_valid high 4 cycles after accept; sum=0x0000, cout=1, ovf=0; in_ready back to 1 the cycle after the DONE handshake.
- Carry-in use: a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure and ignore-while-busy:
  - Toggle in_valid with new operands during ADD → the result is still for the original operands.
  - Hold out_ready=0 for 3 cycles in DONE → out_valid and sum stay stable.
  - Raise out_ready → return to IDLE.
- Reset mid-operation: accept a=0xABCD, b=0x1111, then assert rst on the 2nd ADD cycle → next cycle state=IDLE, sum=0, out_valid=0. A new transaction a=0x0001, b=0x0002 then yields sum=0x0003 with no residue.
